waveform_playback_sequencer: RTL and testbench

- Generates the BRAM read-port address stream for the OSERDES function generator.
- Replaces the free-running read counter with armed, triggered, bounded playback over a programmable address window, repeated a programmable number of times.
- Sits between the SPI-written control registers / BRAM read port and the 8-bit OSERDES word input.
- Runs entirely in the word_clock domain; emits the idle word whenever it is not playing.

---
 rtl/waveform_playback_sequencer.sv | 133 +++++++++++++
 tb/tb_waveform_playback_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_playback_sequencer.sv
// rtl/waveform_playback_sequencer.sv - armed, triggered, looped BRAM address sequencer for the OSERDES word path
// Plays the window start..end (inclusive, wrapping through 0) loop_count times; loop_count 0 plays forever.

module waveform_playback_sequencer #(
    parameter int         ADDRESS_WIDTH = 14,
    parameter int         COUNT_WIDTH   = 16,
    parameter logic [7:0] IDLE_WORD     = 8'h00
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] start_address,
    input  logic [ADDRESS_WIDTH-1:0] end_address,
    input  logic [COUNT_WIDTH-1:0]   loop_count,
    input  logic                     arm,
    input  logic                     software_trigger,
    input  logic                     external_trigger,
    input  logic                     trigger_select,
    input  logic                     abort,
    output logic [ADDRESS_WIDTH-1:0] read_address,
    input  logic [7:0]               word_in,
    output logic [7:0]               word_out,
    output logic                     armed,
    output logic                     busy,
    output logic                     done,
    output logic [COUNT_WIDTH-1:0]   loops_completed
);

    typedef enum logic [1:0] {IDLE, ARMED, PLAYING, FLUSH} state_t;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] start_s;
    logic [ADDRESS_WIDTH-1:0] end_s;
    logic [COUNT_WIDTH-1:0]   loop_count_s;
    logic                     ext_meta;
    logic                     ext_sync;
    logic                     ext_sync_d;
    logic                     trigger_ext;
    logic                     trigger;
    logic                     fetch_valid;
    logic [COUNT_WIDTH-1:0]   loops_plus_one;
    logic [COUNT_WIDTH-1:0]   loops_next;
    logic                     last_pass;

    assign trigger_ext    = ext_sync & ~ext_sync_d;
    assign trigger        = trigger_select ? trigger_ext : software_trigger;
    assign loops_plus_one = loops_completed + COUNT_WIDTH'(1);
    assign loops_next     = (&loops_completed) ? loops_completed : loops_plus_one;
    assign last_pass      = (loop_count_s != '0) && (loops_plus_one == loop_count_s);

    // BRAM has one cycle of read latency, so fetch_valid lines word_in up with its address.
    assign word_out = fetch_valid ? word_in : IDLE_WORD;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ext_meta   <= 1'b0;
            ext_sync   <= 1'b0;
            ext_sync_d <= 1'b0;
        end else begin
            ext_meta   <= external_trigger;
            ext_sync   <= ext_meta;
            ext_sync_d <= ext_sync;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            read_address    <= '0;
            loops_completed <= '0;
            start_s         <= '0;
            end_s           <= '0;
            loop_count_s    <= '0;
            armed           <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            fetch_valid     <= 1'b0;
        end else begin
            done        <= 1'b0;
            fetch_valid <= (state == PLAYING) && !abort;
            if (abort) begin
                state <= IDLE;
                armed <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            start_s         <= start_address;
                            end_s           <= end_address;
                            loop_count_s    <= loop_count;
                            loops_completed <= '0;
                            armed           <= 1'b1;
                            state           <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (trigger) begin
                            read_address <= start_s;
                            armed        <= 1'b0;
                            busy         <= 1'b1;
                            state        <= PLAYING;
                        end else if (arm) begin
                            start_s         <= start_address;
                            end_s           <= end_address;
                            loop_count_s    <= loop_count;
                            loops_completed <= '0;
                        end
                    end
                    PLAYING: begin
                        if (read_address != end_s) begin
                            read_address <= read_address + ADDRESS_WIDTH'(1);
                        end else begin
                            loops_completed <= loops_next;
                            // The final pass holds the address so FLUSH re-reads nothing new.
                            if (last_pass) begin
                                state <= FLUSH;
                            end else begin
                                read_address <= start_s;
                            end
                        end
                    end
                    FLUSH: begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_waveform_playback_sequencer.sv
// tb/tb_waveform_playback_sequencer.sv - scoreboard bench for waveform_playback_sequencer

module tb_waveform_playback_sequencer;

    localparam int AW = 14;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] start_address;
    logic [AW-1:0] end_address;
    logic [CW-1:0] loop_count;
    logic          arm;
    logic          software_trigger;
    logic          external_trigger;
    logic          trigger_select;
    logic          abort;
    logic [AW-1:0] read_address;
    logic [7:0]    word_in;
    logic [7:0]    word_out;
    logic          armed;
    logic          busy;
    logic          done;
    logic [CW-1:0] loops_completed;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [7:0]    exp_word_q[$];

    always #5 clock = ~clock;

    // BRAM model: mem[a] = a[7:0], one-cycle registered read
    always @(posedge clock) word_in <= read_address[7:0];

    waveform_playback_sequencer dut (
        .clock            (clock),
        .reset            (reset),
        .start_address    (start_address),
        .end_address      (end_address),
        .loop_count       (loop_count),
        .arm              (arm),
        .software_trigger (software_trigger),
        .external_trigger (external_trigger),
        .trigger_select   (trigger_select),
        .abort            (abort),
        .read_address     (read_address),
        .word_in          (word_in),
        .word_out         (word_out),
        .armed            (armed),
        .busy             (busy),
        .done             (done),
        .loops_completed  (loops_completed)
    );

    task automatic expect_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic arm_window(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic [CW-1:0] n);
        start_address = s;
        end_address   = e;
        loop_count    = n;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        expect_eq("armed_after_arm", 32'(armed), 1);
        expect_eq("loops_cleared", 32'(loops_completed), 0);
    endtask

    task automatic push_expected(input logic [AW-1:0] s, input logic [AW-1:0] e, input int passes);
        logic [AW-1:0] a;
        for (int p = 0; p < passes; p++) begin
            a = s;
            while (1) begin
                exp_addr_q.push_back(a);
                exp_word_q.push_back(a[7:0]);
                if (a == e) break;
                a = a + 1'b1;
            end
        end
    endtask

    task automatic play_and_check(input bit use_ext, input bit rearm_mid, input int exp_loops);
        int n;
        n = exp_addr_q.size();
        if (use_ext) begin
            external_trigger = 1'b1;
            tick();
            expect_eq("ext_busy_1", 32'(busy), 0);
            tick();
            expect_eq("ext_busy_2", 32'(busy), 0);
            tick();
        end else begin
            software_trigger = 1'b1;
            tick();
            software_trigger = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            expect_eq("addr", 32'(read_address), 32'(exp_addr_q.pop_front()));
            expect_eq("busy_play", 32'(busy), 1);
            if (i > 0) expect_eq("word", 32'(word_out), 32'(exp_word_q.pop_front()));
            if (rearm_mid && i == 1) begin
                start_address = 14'h040;
                end_address   = 14'h041;
                arm = 1'b1;
            end else begin
                arm = 1'b0;
            end
            tick();
        end
        arm = 1'b0;
        expect_eq("word_last", 32'(word_out), 32'(exp_word_q.pop_front()));
        expect_eq("flush_busy", 32'(busy), 1);
        expect_eq("flush_done", 32'(done), 0);
        tick();
        expect_eq("done_pulse", 32'(done), 1);
        expect_eq("busy_after", 32'(busy), 0);
        expect_eq("word_idle", 32'(word_out), 0);
        expect_eq("loops_final", 32'(loops_completed), 32'(exp_loops));
        tick();
        expect_eq("done_single", 32'(done), 0);
    endtask

    initial begin
        reset            = 1'b0;
        start_address    = '0;
        end_address      = '0;
        loop_count       = '0;
        arm              = 1'b0;
        software_trigger = 1'b0;
        external_trigger = 1'b0;
        trigger_select   = 1'b0;
        abort            = 1'b0;
        tick();
        tick();
        expect_eq("rst_addr", 32'(read_address), 0);
        expect_eq("rst_word", 32'(word_out), 0);
        expect_eq("rst_flags", {29'd0, armed, busy, done}, 0);
        expect_eq("rst_loops", 32'(loops_completed), 0);
        reset = 1'b1;
        tick();

        // basic two-pass window
        arm_window(14'h010, 14'h013, 16'd2);
        push_expected(14'h010, 14'h013, 2);
        play_and_check(1'b0, 1'b0, 2);

        // window wrapping through zero
        arm_window(14'h3FFE, 14'h0001, 16'd1);
        push_expected(14'h3FFE, 14'h0001, 1);
        play_and_check(1'b0, 1'b0, 1);

        // arm while playing is ignored; old window continues
        arm_window(14'h030, 14'h033, 16'd1);
        push_expected(14'h030, 14'h033, 1);
        play_and_check(1'b0, 1'b1, 1);

        // external trigger selected: software trigger ignored
        trigger_select = 1'b1;
        arm_window(14'h020, 14'h021, 16'd1);
        software_trigger = 1'b1;
        tick();
        software_trigger = 1'b0;
        expect_eq("sw_ignored_armed", 32'(armed), 1);
        expect_eq("sw_ignored_busy", 32'(busy), 0);
        push_expected(14'h020, 14'h021, 1);
        play_and_check(1'b1, 1'b0, 1);
        // held-high external trigger must not retrigger
        arm_window(14'h020, 14'h021, 16'd1);
        for (int i = 0; i < 5; i++) tick();
        expect_eq("ext_hold_busy", 32'(busy), 0);
        expect_eq("ext_hold_armed", 32'(armed), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        external_trigger = 1'b0;
        trigger_select   = 1'b0;
        expect_eq("abort_armed", 32'(armed), 0);

        // trigger in IDLE is not remembered
        software_trigger = 1'b1;
        tick();
        software_trigger = 1'b0;
        expect_eq("idle_trig_busy", 32'(busy), 0);
        arm_window(14'h050, 14'h051, 16'd1);
        tick();
        expect_eq("idle_trig_forgot", 32'(busy), 0);

        // abort beats trigger in ARMED
        abort = 1'b1;
        software_trigger = 1'b1;
        tick();
        abort = 1'b0;
        software_trigger = 1'b0;
        expect_eq("abort_trig_armed", 32'(armed), 0);
        expect_eq("abort_trig_busy", 32'(busy), 0);
        tick();
        expect_eq("abort_trig_busy2", 32'(busy), 0);

        // infinite playback, then abort
        arm_window(14'h005, 14'h006, 16'd0);
        software_trigger = 1'b1;
        tick();
        software_trigger = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            expect_eq("forever_addr", 32'(read_address), (i % 2 == 0) ? 32'h5 : 32'h6);
            tick();
        end
        expect_eq("forever_loops", 32'(loops_completed), 500);
        expect_eq("forever_busy", 32'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_eq("abort_word", 32'(word_out), 0);
        expect_eq("abort_busy", 32'(busy), 0);
        expect_eq("abort_done", 32'(done), 0);
        expect_eq("abort_loops", 32'(loops_completed), 500);
        tick();
        expect_eq("abort_done2", 32'(done), 0);
        expect_eq("abort_word2", 32'(word_out), 0);

        // asynchronous reset mid-playback
        arm_window(14'h000, 14'h0FF, 16'd0);
        software_trigger = 1'b1;
        tick();
        software_trigger = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        #2 reset = 1'b0;
        #1;
        expect_eq("async_addr", 32'(read_address), 0);
        expect_eq("async_word", 32'(word_out), 0);
        expect_eq("async_flags", {29'd0, armed, busy, done}, 0);
        expect_eq("async_loops", 32'(loops_completed), 0);
        tick();
        reset = 1'b1;
        tick();
        expect_eq("post_rst_flags", {29'd0, armed, busy, done}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
